// File: rtl/chacha20_pkg.sv
// chacha20_pkg: shared state encoding, widths and channel helper for the chacha20 arbiter
package chacha20_pkg;

    localparam int KEY_W   = 256;
    localparam int NONCE_W = 96;
    localparam int CTR_W   = 32;
    localparam int WORD_W  = 32;

    typedef enum logic [1:0] {IDLE, START, STREAM, DRAIN} state_t;

    function automatic logic [1:0] chan_mask(input logic ch);
        return ch ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/chacha20_rr_arb_2.sv
// chacha20_rr_arb_2: two-way round-robin picker, ptr names the favoured channel on contention
module chacha20_rr_arb_2
    import chacha20_pkg::*;
(
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt_onehot
);

    assign gnt_onehot = (&req) ? chan_mask(ptr) : req;

endmodule

// File: rtl/chacha20_stream_arbiter.sv
// chacha20_stream_arbiter: message-granular two-channel sequencer for a shared chacha20 core (optional watchdog: CHACHA20_ARB_TIMEOUT_EN)
module chacha20_stream_arbiter
    import chacha20_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int FIRST_PRIO     = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ch0_req,
    input  logic [KEY_W-1:0]   ch0_key,
    input  logic [NONCE_W-1:0] ch0_nonce,
    input  logic [CTR_W-1:0]   ch0_counter,
    output logic               ch0_gnt,
    input  logic [WORD_W-1:0]  ch0_pt_data,
    input  logic               ch0_pt_valid,
    input  logic               ch0_pt_last,
    output logic               ch0_pt_ready,
    output logic [WORD_W-1:0]  ch0_ct_data,
    output logic               ch0_ct_valid,
    output logic               ch0_ct_last,
    input  logic               ch0_ct_ready,
    output logic               ch0_done,
    output logic               ch0_err,
    input  logic               ch1_req,
    input  logic [KEY_W-1:0]   ch1_key,
    input  logic [NONCE_W-1:0] ch1_nonce,
    input  logic [CTR_W-1:0]   ch1_counter,
    output logic               ch1_gnt,
    input  logic [WORD_W-1:0]  ch1_pt_data,
    input  logic               ch1_pt_valid,
    input  logic               ch1_pt_last,
    output logic               ch1_pt_ready,
    output logic [WORD_W-1:0]  ch1_ct_data,
    output logic               ch1_ct_valid,
    output logic               ch1_ct_last,
    input  logic               ch1_ct_ready,
    output logic               ch1_done,
    output logic               ch1_err,
    output logic               core_start,
    output logic [KEY_W-1:0]   core_key,
    output logic [NONCE_W-1:0] core_nonce,
    output logic [CTR_W-1:0]   core_counter,
    output logic [WORD_W-1:0]  core_pt_data,
    output logic               core_pt_valid,
    output logic               core_pt_last,
    input  logic               core_pt_ready,
    input  logic [WORD_W-1:0]  core_ct_data,
    input  logic               core_ct_valid,
    input  logic               core_ct_last,
    output logic               core_ct_ready,
    input  logic               core_done
);

    state_t            state;
    logic              sel;
    logic              rr_ptr;
    logic [1:0]        gnt;
    logic [1:0]        done;
    logic [1:0]        err;
    logic [1:0]        pick;
    logic              streaming;
    logic              passing;
    logic [WORD_W-1:0] g_pt_data;
    logic              g_pt_valid;
    logic              g_pt_last;
    logic              g_ct_ready;
    logic              pt_hs;
    logic              wd_hit;
    logic              fin_ok;
    logic              fin_err;

    chacha20_rr_arb_2 u_rr (
        .req        ({ch1_req, ch0_req}),
        .ptr        (rr_ptr),
        .gnt_onehot (pick)
    );

    assign ch0_gnt  = gnt[0];
    assign ch1_gnt  = gnt[1];
    assign ch0_done = done[0];
    assign ch1_done = done[1];
    assign ch0_err  = err[0];
    assign ch1_err  = err[1];

    assign streaming = state == STREAM;
    assign passing   = streaming || state == DRAIN;

    assign g_pt_data  = sel ? ch1_pt_data  : ch0_pt_data;
    assign g_pt_valid = sel ? ch1_pt_valid : ch0_pt_valid;
    assign g_pt_last  = sel ? ch1_pt_last  : ch0_pt_last;
    assign g_ct_ready = sel ? ch1_ct_ready : ch0_ct_ready;

    assign core_pt_data  = streaming ? g_pt_data : '0;
    assign core_pt_valid = streaming && g_pt_valid;
    assign core_pt_last  = streaming && g_pt_last;
    assign ch0_pt_ready  = streaming && !sel && core_pt_ready;
    assign ch1_pt_ready  = streaming && sel && core_pt_ready;

    assign ch0_ct_data   = (passing && !sel) ? core_ct_data : '0;
    assign ch0_ct_valid  = passing && !sel && core_ct_valid;
    assign ch0_ct_last   = passing && !sel && core_ct_last;
    assign ch1_ct_data   = (passing && sel) ? core_ct_data : '0;
    assign ch1_ct_valid  = passing && sel && core_ct_valid;
    assign ch1_ct_last   = passing && sel && core_ct_last;
    assign core_ct_ready = passing && g_ct_ready;

    assign pt_hs = core_pt_valid && core_pt_ready;

`ifdef CHACHA20_ARB_TIMEOUT_EN
    logic [15:0] wd;
    logic        ct_hs;

    assign ct_hs  = core_ct_valid && core_ct_ready;
    assign wd_hit = passing && !(pt_hs || ct_hs) && wd == 16'(TIMEOUT_CYCLES - 1);

    // watchdog: count idle handshake cycles while a session owns the core
    always_ff @(posedge clk) begin
        if (rst || !passing || pt_hs || ct_hs) wd <= '0;
        else wd <= wd + 16'd1;
    end
`else
    assign wd_hit = 1'b0;
`endif

    // a clean finish only comes from DRAIN; done anywhere earlier, or a stall, aborts
    assign fin_ok  = state == DRAIN && core_done;
    assign fin_err = ((state == START || streaming) && core_done) || (wd_hit && !fin_ok);

    // session sequencer: grant, start pulse, stream, drain, release with done/err
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rr_ptr       <= FIRST_PRIO != 0;
            sel          <= 1'b0;
            gnt          <= '0;
            done         <= '0;
            err          <= '0;
            core_start   <= 1'b0;
            core_key     <= '0;
            core_nonce   <= '0;
            core_counter <= '0;
        end else begin
            core_start <= 1'b0;
            done       <= '0;
            err        <= '0;
            if (fin_ok || fin_err) begin
                done   <= fin_ok  ? chan_mask(sel) : 2'b00;
                err    <= fin_err ? chan_mask(sel) : 2'b00;
                gnt    <= '0;
                rr_ptr <= !sel;
                state  <= IDLE;
            end else begin
                case (state)
                    IDLE: if (|pick) begin
                        sel          <= pick[1];
                        gnt          <= pick;
                        core_start   <= 1'b1;
                        core_key     <= pick[1] ? ch1_key     : ch0_key;
                        core_nonce   <= pick[1] ? ch1_nonce   : ch0_nonce;
                        core_counter <= pick[1] ? ch1_counter : ch0_counter;
                        state        <= START;
                    end
                    START:   state <= STREAM;
                    STREAM:  if (pt_hs && core_pt_last) state <= DRAIN;
                    default: state <= state;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_chacha20_stream_arbiter.sv
// tb_chacha20_stream_arbiter: directed self-checking bench for the chacha20 stream arbiter
module tb_chacha20_stream_arbiter;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         ch0_req = 0, ch1_req = 0;
    logic [255:0] ch0_key = '0, ch1_key = '0;
    logic [95:0]  ch0_nonce = '0, ch1_nonce = '0;
    logic [31:0]  ch0_counter = '0, ch1_counter = '0;
    logic         ch0_gnt, ch1_gnt;
    logic [31:0]  ch0_pt_data = '0, ch1_pt_data = '0;
    logic         ch0_pt_valid = 0, ch1_pt_valid = 0, ch0_pt_last = 0, ch1_pt_last = 0;
    logic         ch0_pt_ready, ch1_pt_ready;
    logic [31:0]  ch0_ct_data, ch1_ct_data;
    logic         ch0_ct_valid, ch1_ct_valid, ch0_ct_last, ch1_ct_last;
    logic         ch0_ct_ready = 0, ch1_ct_ready = 0;
    logic         ch0_done, ch1_done, ch0_err, ch1_err;
    logic         core_start;
    logic [255:0] core_key;
    logic [95:0]  core_nonce;
    logic [31:0]  core_counter;
    logic [31:0]  core_pt_data;
    logic         core_pt_valid, core_pt_last;
    logic         core_pt_ready = 0;
    logic [31:0]  core_ct_data = '0;
    logic         core_ct_valid = 0, core_ct_last = 0;
    logic         core_ct_ready;
    logic         core_done = 0;

    int tests = 0;
    int fails = 0;

    localparam logic [255:0] K0 = 256'h0001020304050607_08090a0b0c0d0e0f_1011121314151617_18191a1b1c1d1e1f;
    localparam logic [255:0] K1 = 256'hdeadbeefcafef00d_0123456789abcdef_fedcba9876543210_a5a5a5a55a5a5a5a;

    chacha20_stream_arbiter #(.TIMEOUT_CYCLES(8), .FIRST_PRIO(0)) dut (
        .clk(clk), .rst(rst),
        .ch0_req(ch0_req), .ch0_key(ch0_key), .ch0_nonce(ch0_nonce), .ch0_counter(ch0_counter),
        .ch0_gnt(ch0_gnt), .ch0_pt_data(ch0_pt_data), .ch0_pt_valid(ch0_pt_valid),
        .ch0_pt_last(ch0_pt_last), .ch0_pt_ready(ch0_pt_ready), .ch0_ct_data(ch0_ct_data),
        .ch0_ct_valid(ch0_ct_valid), .ch0_ct_last(ch0_ct_last), .ch0_ct_ready(ch0_ct_ready),
        .ch0_done(ch0_done), .ch0_err(ch0_err),
        .ch1_req(ch1_req), .ch1_key(ch1_key), .ch1_nonce(ch1_nonce), .ch1_counter(ch1_counter),
        .ch1_gnt(ch1_gnt), .ch1_pt_data(ch1_pt_data), .ch1_pt_valid(ch1_pt_valid),
        .ch1_pt_last(ch1_pt_last), .ch1_pt_ready(ch1_pt_ready), .ch1_ct_data(ch1_ct_data),
        .ch1_ct_valid(ch1_ct_valid), .ch1_ct_last(ch1_ct_last), .ch1_ct_ready(ch1_ct_ready),
        .ch1_done(ch1_done), .ch1_err(ch1_err),
        .core_start(core_start), .core_key(core_key), .core_nonce(core_nonce),
        .core_counter(core_counter), .core_pt_data(core_pt_data), .core_pt_valid(core_pt_valid),
        .core_pt_last(core_pt_last), .core_pt_ready(core_pt_ready), .core_ct_data(core_ct_data),
        .core_ct_valid(core_ct_valid), .core_ct_last(core_ct_last), .core_ct_ready(core_ct_ready),
        .core_done(core_done)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // called in STREAM: push a final beat, then report core done from DRAIN
    task automatic end_session(input bit ch);
        if (ch) begin ch1_pt_valid = 1; ch1_pt_last = 1; end
        else begin ch0_pt_valid = 1; ch0_pt_last = 1; end
        core_pt_ready = 1;
        tick();
        ch0_pt_valid = 0; ch0_pt_last = 0; ch1_pt_valid = 0; ch1_pt_last = 0;
        core_pt_ready = 0;
        core_done = 1;
        tick();
        core_done = 0;
    endtask

    task automatic test_reset;
        do_reset();
        tests++;
        if ({ch0_gnt, ch1_gnt, core_start, ch0_done, ch1_done, ch0_err, ch1_err, core_ct_ready, core_pt_valid} !== 9'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got %b want 000000000", {ch0_gnt, ch1_gnt, core_start, ch0_done, ch1_done, ch0_err, ch1_err, core_ct_ready, core_pt_valid});
        end
        tests++;
        if (core_key !== '0 || core_counter !== '0 || core_nonce !== '0) begin
            fails++;
            $display("FAIL reset_cfg: got key %h ctr %h want 0", core_key, core_counter);
        end
    endtask

    task automatic test_single;
        ch0_key = K0; ch0_nonce = 96'h0a0b0c0d0e0f101112131415; ch0_counter = 32'h1;
        ch0_req = 1;
        tick();
        ch0_req = 0;
        tests++;
        if ({ch0_gnt, ch1_gnt, core_start} !== 3'b101) begin
            fails++; $display("FAIL single_grant: got gnt0/gnt1/start %b want 101", {ch0_gnt, ch1_gnt, core_start});
        end
        tests++;
        if (core_key !== K0) begin fails++; $display("FAIL single_key: got %h want %h", core_key, K0); end
        tick();
        ch0_key = K1;
        tests++;
        if ({ch0_gnt, core_start} !== 2'b10) begin
            fails++; $display("FAIL single_start_pulse: got gnt/start %b want 10", {ch0_gnt, core_start});
        end
        core_pt_ready = 1; ch0_pt_valid = 1; ch0_ct_ready = 1;
        for (int i = 1; i <= 3; i++) begin
            ch0_pt_data = 32'h11111111 * i;
            ch0_pt_last = (i == 3);
            core_ct_valid = 1; core_ct_data = 32'hAAAA0000 + i;
            #1;
            tests++;
            if ({core_pt_data, core_pt_valid, core_pt_last, ch0_pt_ready, ch1_pt_ready} !== {32'h11111111 * i, 1'b1, i == 3, 1'b1, 1'b0}) begin
                fails++; $display("FAIL single_pt_beat%0d: got data %h v %b l %b rdy %b want %h", i, core_pt_data, core_pt_valid, core_pt_last, ch0_pt_ready, 32'h11111111 * i);
            end
            tests++;
            if ({ch0_ct_data, ch0_ct_valid, core_ct_ready, ch1_ct_valid} !== {32'hAAAA0000 + i, 1'b1, 1'b1, 1'b0}) begin
                fails++; $display("FAIL single_ct_beat%0d: got data %h v %b rdy %b ch1v %b", i, ch0_ct_data, ch0_ct_valid, core_ct_ready, ch1_ct_valid);
            end
            tick();
        end
        ch0_pt_last = 0;
        #1;
        tests++;
        if ({core_pt_valid, ch0_pt_ready, ch0_ct_valid} !== 3'b001) begin
            fails++; $display("FAIL single_drain: got ptv/ptrdy/ctv %b want 001", {core_pt_valid, ch0_pt_ready, ch0_ct_valid});
        end
        tests++;
        if (core_key !== K0) begin fails++; $display("FAIL single_key_held: got %h want %h", core_key, K0); end
        ch0_pt_valid = 0; core_ct_valid = 0; ch0_ct_ready = 0; core_pt_ready = 0;
        core_done = 1;
        tick();
        core_done = 0;
        tests++;
        if ({ch0_done, ch0_err, ch0_gnt} !== 3'b100) begin
            fails++; $display("FAIL single_done: got done/err/gnt %b want 100", {ch0_done, ch0_err, ch0_gnt});
        end
        tick();
        tests++;
        if ({ch0_done, ch0_gnt, core_start} !== 3'b000) begin
            fails++; $display("FAIL single_done_pulse: got done/gnt/start %b want 000", {ch0_done, ch0_gnt, core_start});
        end
    endtask

    task automatic test_contention;
        do_reset();
        ch0_counter = 32'h00000100; ch1_counter = 32'h00000007; ch1_key = K1;
        ch0_req = 1; ch1_req = 1;
        tick();
        tests++;
        if ({ch0_gnt, ch1_gnt, core_counter} !== {2'b10, 32'h00000100}) begin
            fails++; $display("FAIL cont_first: got gnt %b ctr %h want 10 00000100", {ch0_gnt, ch1_gnt}, core_counter);
        end
        tick();
        end_session(0);
        tick();
        tests++;
        if ({ch0_gnt, ch1_gnt, core_counter, core_key} !== {2'b01, 32'h00000007, K1}) begin
            fails++; $display("FAIL cont_second: got gnt %b ctr %h want 01 00000007", {ch0_gnt, ch1_gnt}, core_counter);
        end
        tick();
        end_session(1);
        tick();
        ch0_req = 0; ch1_req = 0;
        tests++;
        if ({ch0_gnt, ch1_gnt} !== 2'b10) begin
            fails++; $display("FAIL cont_third: got gnt %b want 10", {ch0_gnt, ch1_gnt});
        end
        tick();
        end_session(0);
    endtask

    task automatic test_backpressure;
        ch1_req = 1;
        tick();
        ch1_req = 0;
        tick();
        core_ct_valid = 1; core_ct_data = 32'hC0DE0001; ch1_ct_ready = 0; ch0_ct_ready = 1;
        for (int i = 0; i < 5; i++) begin
            #1;
            tests++;
            if ({core_ct_ready, ch1_ct_valid, ch0_ct_valid, ch1_ct_data, ch0_ct_data} !== {3'b010, 32'hC0DE0001, 32'h0}) begin
                fails++; $display("FAIL bp_stall%0d: got rdy %b v1 %b v0 %b d1 %h d0 %h", i, core_ct_ready, ch1_ct_valid, ch0_ct_valid, ch1_ct_data, ch0_ct_data);
            end
            tick();
        end
        ch1_ct_ready = 1;
        for (int i = 1; i <= 2; i++) begin
            core_ct_data = 32'hC0DE0000 + i;
            #1;
            tests++;
            if ({core_ct_ready, ch1_ct_valid, ch0_ct_valid, ch1_ct_data} !== {3'b110, 32'hC0DE0000 + i}) begin
                fails++; $display("FAIL bp_flow%0d: got rdy %b v1 %b v0 %b d1 %h", i, core_ct_ready, ch1_ct_valid, ch0_ct_valid, ch1_ct_data);
            end
            tick();
        end
        core_ct_valid = 0; ch1_ct_ready = 0; ch0_ct_ready = 0;
        end_session(1);
        tests++;
        if ({ch1_done, ch1_gnt} !== 2'b10) begin
            fails++; $display("FAIL bp_done: got done/gnt %b want 10", {ch1_done, ch1_gnt});
        end
    endtask

    task automatic test_protocol_error;
        tick();
        ch0_req = 1;
        tick();
        ch0_req = 0;
        tick();
        ch0_pt_valid = 1; ch0_pt_data = 32'h44444444; core_pt_ready = 1;
        tick();
        ch0_pt_valid = 0; core_pt_ready = 0;
        core_done = 1;
        tick();
        core_done = 0;
        tests++;
        if ({ch0_err, ch0_done, ch0_gnt} !== 3'b100) begin
            fails++; $display("FAIL perr_pulse: got err/done/gnt %b want 100", {ch0_err, ch0_done, ch0_gnt});
        end
        tick();
        tests++;
        if ({ch0_err, ch0_done, ch0_gnt, core_start} !== 4'b0000) begin
            fails++; $display("FAIL perr_idle: got err/done/gnt/start %b want 0000", {ch0_err, ch0_done, ch0_gnt, core_start});
        end
    endtask

    task automatic test_reset_mid;
        ch0_key = K0;
        ch0_req = 1;
        tick();
        ch0_req = 0;
        tick();
        ch0_pt_valid = 1; ch0_pt_last = 1; core_pt_ready = 1;
        tick();
        ch0_pt_valid = 0; ch0_pt_last = 0; core_pt_ready = 0;
        core_ct_valid = 1; ch0_ct_ready = 1; core_ct_data = 32'h5555AAAA;
        rst = 1;
        tick();
        rst = 0;
        #1;
        tests++;
        if ({ch0_gnt, ch1_gnt, core_start, core_ct_ready, ch0_ct_valid, ch0_ct_data, core_key, core_counter} !== '0) begin
            fails++; $display("FAIL rstmid_outputs: got gnt %b start %b ctrdy %b ctv %b key %h", {ch0_gnt, ch1_gnt}, core_start, core_ct_ready, ch0_ct_valid, core_key);
        end
        core_ct_valid = 0; ch0_ct_ready = 0;
        ch0_req = 1; ch1_req = 1;
        tick();
        ch0_req = 0; ch1_req = 0;
        tests++;
        if ({ch0_gnt, ch1_gnt} !== 2'b10) begin
            fails++; $display("FAIL rstmid_rr: got gnt %b want 10", {ch0_gnt, ch1_gnt});
        end
        tick();
        end_session(0);
    endtask

    task automatic test_timeout;
        tick();
        ch0_req = 1;
        tick();
        ch0_req = 0;
        tick();
`ifdef CHACHA20_ARB_TIMEOUT_EN
        for (int i = 0; i < 7; i++) tick();
        tests++;
        if ({ch0_gnt, ch0_err} !== 2'b10) begin
            fails++; $display("FAIL timeout_early: got gnt/err %b want 10", {ch0_gnt, ch0_err});
        end
        tick();
        tests++;
        if ({ch0_gnt, ch0_err, ch0_done} !== 3'b010) begin
            fails++; $display("FAIL timeout_abort: got gnt/err/done %b want 010", {ch0_gnt, ch0_err, ch0_done});
        end
`else
        for (int i = 0; i < 40; i++) tick();
        tests++;
        if ({ch0_gnt, ch0_err} !== 2'b10) begin
            fails++; $display("FAIL timeout_hold: got gnt/err %b want 10", {ch0_gnt, ch0_err});
        end
        end_session(0);
        tests++;
        if ({ch0_done, ch0_err, ch0_gnt} !== 3'b100) begin
            fails++; $display("FAIL timeout_finish: got done/err/gnt %b want 100", {ch0_done, ch0_err, ch0_gnt});
        end
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_protocol_error();
        test_reset_mid();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
